// File: rtl/ram_sync_core.sv
// ram_sync_core: synchronous single-port RAM with a one-cycle registered read
// port and a self-clear sweep that zeroes every word after each reset.
// Optional feature macro: RAM_SYNC_CORE_PARITY_EN adds the q_par output,
// the XOR reduction of the word presented on q.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_CLEAR | sweeping clr_ptr over all words writing zero; busy=1,
//          | we/re ignored, q and q_valid held at reset values
// ST_RUN   | normal operation; we/re honoured on the shared addr
module ram_sync_core #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic              busy
`ifdef RAM_SYNC_CORE_PARITY_EN
  ,
  output logic              q_par
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] clr_ptr;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_wr;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              rd_fire;
  logic [DATA_W-1:0] rd_word;

  // Next-state and per-cycle memory/read commands; rst overrides everything
  // so the reset edge neither writes memory nor launches a read.
  always_comb begin
    state_next  = state;
    mem_wr      = 1'b0;
    mem_wr_addr = addr;
    mem_wr_data = data;
    rd_fire     = 1'b0;
    case (state)
      ST_CLEAR: begin
        mem_wr      = 1'b1;
        mem_wr_addr = clr_ptr;
        mem_wr_data = '0;
        if (clr_ptr == LAST_PTR) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        mem_wr  = we;
        rd_fire = re;
      end
      default: begin
        state_next = ST_CLEAR;
      end
    endcase
    if (rst) begin
      state_next = ST_CLEAR;
      mem_wr     = 1'b0;
      rd_fire    = 1'b0;
    end
  end

  // Write-first: a read colliding with a write returns the incoming data.
  // addr is shared, so any simultaneous we/re is a same-address collision.
  always_comb begin
    rd_word = we ? data : mem[addr];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CLEAR;
    end else begin
      state <= state_next;
    end
  end

  // Sweep pointer; wraps to zero naturally after the last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_ptr <= '0;
    end else if (state == ST_CLEAR) begin
      clr_ptr <= clr_ptr + 1'b1;
    end
  end

  // busy drops on the same edge that writes the last word of the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b1;
    end else if (state == ST_CLEAR && clr_ptr == LAST_PTR) begin
      busy <= 1'b0;
    end
  end

  // Storage array; not reset, the sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[mem_wr_addr] <= mem_wr_data;
    end
  end

  // Registered read port: q holds its last value when no read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else if (rd_fire) begin
      q       <= rd_word;
      q_valid <= 1'b1;
    end else begin
      q_valid <= 1'b0;
    end
  end

`ifdef RAM_SYNC_CORE_PARITY_EN
  // Parity of the word loaded into q, updated in lockstep with q.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_par <= 1'b0;
    end else if (rd_fire) begin
      q_par <= ^rd_word;
    end
  end
`endif

endmodule

// File: tb/tb_ram_sync_core.sv
// Scoreboard bench for ram_sync_core: a driver updates an array-based
// reference model at each clock edge and queues expected read words; a
// negedge monitor pops and compares whenever q_valid is high.
module tb_ram_sync_core;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       we = 1'b0;
  logic       re = 1'b0;
  logic [3:0] addr = '0;
  logic [3:0] data = '0;
  logic [3:0] q;
  logic       q_valid;
  logic       busy;
`ifdef RAM_SYNC_CORE_PARITY_EN
  logic       q_par;
`endif

  ram_sync_core #(.ADDR_W(4), .DATA_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .re      (re),
    .addr    (addr),
    .data    (data),
    .q       (q),
    .q_valid (q_valid),
    .busy    (busy)
`ifdef RAM_SYNC_CORE_PARITY_EN
    ,
    .q_par   (q_par)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [3:0] mdl_mem [DEPTH];
  int         clear_left = 0;
  bit         armed = 1'b0;
  bit         exp_busy = 1'b0;
  bit         exp_valid = 1'b0;
  logic [3:0] exp_q = '0;
  logic [3:0] sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic odd_ones(input logic [3:0] v);
    return ($countones(v) % 2) == 1;
  endfunction

  // Model of what the edge just sampled should do.
  task automatic model_edge();
    if (rst) begin
      armed      = 1'b1;
      clear_left = DEPTH;
      exp_busy   = 1'b1;
      exp_valid  = 1'b0;
      exp_q      = '0;
    end else if (armed) begin
      if (clear_left > 0) begin
        clear_left--;
        exp_valid = 1'b0;
        if (clear_left == 0) begin
          foreach (mdl_mem[i]) mdl_mem[i] = '0;
          exp_busy = 1'b0;
        end
      end else begin
        exp_valid = re;
        if (re) begin
          exp_q = we ? data : mdl_mem[addr];
          sb.push_back(exp_q);
        end
        if (we) mdl_mem[addr] = data;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic op(input bit w, input bit r, input logic [3:0] a, input logic [3:0] d);
    we = w; re = r; addr = a; data = d;
    cycle();
    we = 1'b0; re = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; we = 1'b0; re = 1'b0;
    repeat (n) cycle();
    rst = 1'b0;
  endtask

  // Runs until busy falls (bounded); optionally pokes commands that must be ignored.
  task automatic wait_ready(input bit poke);
    int n = 0;
    while (busy === 1'b1 && n < 64) begin
      n++;
      if (poke && n <= 4) begin
        we = 1'b1; re = 1'b1; addr = 4'h2; data = 4'hF;
      end else begin
        we = 1'b0; re = 1'b0;
      end
      cycle();
    end
    we = 1'b0; re = 1'b0;
    chk("busy_cycles", n, DEPTH);
  endtask

  // Monitor: checks status every cycle and drains the scoreboard on q_valid.
  always @(negedge clk) begin
    if (armed) begin
      chk("busy", busy, exp_busy);
      chk("q_valid", q_valid, exp_valid);
      if (q_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL q_valid_unexpected actual=1 required=0 at %0t", $time);
        end else begin
          logic [3:0] e;
          e = sb.pop_front();
          chk("q_data", q, e);
        end
      end else begin
        chk("q_hold", q, exp_q);
      end
`ifdef RAM_SYNC_CORE_PARITY_EN
      chk("q_par", q_par, odd_ones(exp_q));
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    // Reset clear, with commands poked during the sweep
    do_reset(2);
    wait_ready(1'b1);
    for (int i = 0; i < DEPTH; i++) op(1'b0, 1'b1, 4'(i), 4'h0);
    op(1'b0, 1'b0, 4'h0, 4'h0);

    // Basic write/read, then hold
    op(1'b1, 1'b0, 4'h3, 4'h5);
    op(1'b0, 1'b1, 4'h3, 4'h0);
    repeat (3) op(1'b0, 1'b0, 4'h0, 4'h0);

    // Write-first collision, later readback
    op(1'b1, 1'b1, 4'h7, 4'hA);
    op(1'b0, 1'b0, 4'h0, 4'h0);
    op(1'b0, 1'b1, 4'h7, 4'h0);
    // Address 2 must still be zero after the ignored write
    op(1'b0, 1'b1, 4'h2, 4'h0);
    op(1'b0, 1'b0, 4'h0, 4'h0);

    // Mid-run reset
    op(1'b1, 1'b0, 4'hC, 4'h9);
    op(1'b0, 1'b1, 4'hC, 4'h0);
    do_reset(1);
    wait_ready(1'b0);
    op(1'b0, 1'b1, 4'hC, 4'h0);
    op(1'b0, 1'b0, 4'h0, 4'h0);

    // Parity pair, back-to-back reads
    op(1'b1, 1'b0, 4'h1, 4'h7);
    op(1'b1, 1'b0, 4'h2, 4'h6);
    op(1'b0, 1'b1, 4'h1, 4'h0);
    op(1'b0, 1'b1, 4'h2, 4'h0);
    op(1'b0, 1'b0, 4'h0, 4'h0);

    // Random traffic with occasional resets (including reset alongside reads)
    for (int i = 0; i < 400; i++) begin
      we   = 1'($urandom_range(0, 1));
      re   = 1'($urandom_range(0, 1));
      addr = 4'($urandom_range(0, 15));
      data = 4'($urandom_range(0, 15));
      rst  = ($urandom_range(0, 59) == 0);
      cycle();
    end
    rst = 1'b0; we = 1'b0; re = 1'b0;
    repeat (DEPTH + 2) cycle();

    // Final sweep of contents against the model
    for (int i = 0; i < DEPTH; i++) op(1'b0, 1'b1, 4'(i), 4'h0);
    repeat (3) op(1'b0, 1'b0, 4'h0, 4'h0);

    @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
